// File: rtl/multicycle_cu_pkg.sv
// Shared RV32I control types: instruction formats, ALU ops, FSM states, trap causes
// and the decoded-instruction record passed from rv_decoder to the sequencer.
package riscv_structures;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, INVALID
    } instr_type_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_INVALID
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } cu_state_e;

    typedef enum logic [1:0] {
        TC_ILLEGAL, TC_ECALL, TC_EBREAK, TC_TIMEOUT
    } trap_cause_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JALR = 2'd2;
    localparam logic [1:0] PC_TRAP = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    typedef struct packed {
        instr_type_e instr_type;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        illegal;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_ecall;
        logic        is_ebreak;
        logic        is_csr;
    } dec_t;

    // alt selects SUB/SRA; callers only set it where the encoding allows it
    function automatic alu_op_e alu_map(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_cu_decoder.sv
// Combinational RV32I classifier: latched instruction word -> format, ALU op,
// operand select, legality and per-class flags used by the sequencer.
module rv_decoder
    import riscv_structures::*;
#(
    parameter bit HAS_ZICSR = 1'b0
) (
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    always_comb begin
        dec_o.instr_type = INVALID;
        dec_o.alu_op     = ALU_INVALID;
        dec_o.use_imm    = 1'b0;
        dec_o.illegal    = 1'b0;
        dec_o.is_load    = 1'b0;
        dec_o.is_store   = 1'b0;
        dec_o.is_branch  = 1'b0;
        dec_o.is_jal     = 1'b0;
        dec_o.is_jalr    = 1'b0;
        dec_o.is_ecall   = 1'b0;
        dec_o.is_ebreak  = 1'b0;
        dec_o.is_csr     = 1'b0;
        case (opc)
            OPC_LUI:    begin dec_o.instr_type = U_TYPE; dec_o.alu_op = ALU_PASSB; dec_o.use_imm = 1'b1; end
            OPC_AUIPC:  begin dec_o.instr_type = U_TYPE; dec_o.alu_op = ALU_ADD;   dec_o.use_imm = 1'b1; end
            OPC_JAL:    begin dec_o.instr_type = J_TYPE; dec_o.alu_op = ALU_ADD;   dec_o.use_imm = 1'b1; dec_o.is_jal  = 1'b1; end
            OPC_JALR:   begin dec_o.instr_type = I_TYPE; dec_o.alu_op = ALU_ADD;   dec_o.use_imm = 1'b1; dec_o.is_jalr = 1'b1; end
            OPC_BRANCH: begin dec_o.instr_type = B_TYPE; dec_o.is_branch = 1'b1; end
            OPC_LOAD:   begin dec_o.instr_type = I_TYPE; dec_o.alu_op = ALU_ADD;   dec_o.use_imm = 1'b1; dec_o.is_load  = 1'b1; end
            OPC_STORE:  begin dec_o.instr_type = S_TYPE; dec_o.alu_op = ALU_ADD;   dec_o.use_imm = 1'b1; dec_o.is_store = 1'b1; end
            OPC_OP_IMM: begin
                dec_o.instr_type = I_TYPE;
                dec_o.use_imm    = 1'b1;
                dec_o.alu_op     = alu_map(f3, (f3 == 3'b101) && f7[5]);
                dec_o.illegal    = ((f3 == 3'b001) && (f7 != 7'b0)) ||
                                   ((f3 == 3'b101) && (f7 != 7'b0) && (f7 != 7'b0100000));
            end
            OPC_OP: begin
                dec_o.instr_type = R_TYPE;
                dec_o.alu_op     = alu_map(f3, f7[5]);
                dec_o.illegal    = !((f7 == 7'b0) ||
                                     ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_SYSTEM: begin
                dec_o.instr_type = I_TYPE;
                dec_o.alu_op     = ALU_ADD;
                dec_o.use_imm    = 1'b1;
                // funct3=0: only the exact ECALL/EBREAK encodings are accepted
                if (f3 == 3'b000) begin
                    if ((instr_i[31:21] == 11'b0) && (instr_i[19:7] == 13'b0)) begin
                        dec_o.is_ecall  = !instr_i[20];
                        dec_o.is_ebreak = instr_i[20];
                    end else begin
                        dec_o.illegal = 1'b1;
                    end
                end else if (HAS_ZICSR) begin
                    dec_o.is_csr = 1'b1;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I sequencer: holds the instruction register, steps
// FETCH/DECODE/EXEC/MEM/WB/TRAP and decodes datapath strobes from the state.
module multicycle_cu
    import riscv_structures::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter bit HAS_ZICSR   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            fetch_req,
    output alu_op_e         alu_op,
    output logic            use_imm,
    output instr_type_e     instr_type,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic            pc_write,
    output logic [1:0]      pc_sel,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic            busy
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    cu_state_e   state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    trap_cause_e cause_q, cause_d;
    dec_t        dec;

    rv_decoder #(.HAS_ZICSR(HAS_ZICSR)) u_dec (
        .instr_i (ir_q),
        .dec_o   (dec)
    );

    assign alu_op     = dec.alu_op;
    assign use_imm    = dec.use_imm;
    assign instr_type = dec.instr_type;
    assign trap_cause = cause_q;
    assign busy       = (state_q != S_FETCH);
    assign cnt_inc    = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= 32'h0000_0013;
            cnt_q   <= '0;
            cause_q <= TC_ILLEGAL;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        fetch_req = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        pc_write  = 1'b0;
        pc_sel    = PC_SEQ;
        trap      = 1'b0;
        case (state_q)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr[31:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.illegal) begin
                    cause_d = TC_ILLEGAL;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec.is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken ? PC_BR : PC_SEQ;
                    state_d  = S_FETCH;
                end else if (dec.is_load || dec.is_store) begin
                    state_d = S_MEM;
                end else if (dec.is_ecall || dec.is_ebreak) begin
                    cause_d = dec.is_ecall ? TC_ECALL : TC_EBREAK;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_read  = dec.is_load;
                mem_write = dec.is_store;
                cnt_d     = cnt_inc;
                // a completion in the last allowed cycle still beats the timeout
                if (mem_ready) begin
                    cnt_d = '0;
                    if (dec.is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (cnt_inc == CW'(MEM_TIMEOUT)) begin
                    cnt_d   = '0;
                    cause_d = TC_TIMEOUT;
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write = (ir_q[11:7] != 5'd0);
                wb_sel    = dec.is_load ? WB_MEM :
                            (dec.is_jal || dec.is_jalr) ? WB_PC4 :
                            dec.is_csr ? WB_CSR : WB_ALU;
                pc_write  = 1'b1;
                pc_sel    = dec.is_jal ? PC_BR : dec.is_jalr ? PC_JALR : PC_SEQ;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                trap     = 1'b1;
                pc_write = 1'b1;
                pc_sel   = PC_TRAP;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: runs single instructions through the FSM and
// checks per-instruction strobe summaries against hand-computed values.
module tb_multicycle_cu;
    import riscv_structures::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        fetch_req, use_imm, mem_read, mem_write, reg_write;
    logic        pc_write, trap, busy;
    logic [1:0]  wb_sel, pc_sel, trap_cause;
    alu_op_e     alu_op;
    instr_type_e instr_type;

    int n_tests = 0;
    int n_fail  = 0;

    int          s_cyc, s_pcw, s_rw, s_trap, s_mem;
    logic [31:0] s_sel, s_wb, s_cause, s_alu, s_imm, s_type;

    multicycle_cu #(.XLEN(32), .MEM_TIMEOUT(4), .HAS_ZICSR(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .fetch_req(fetch_req),
        .alu_op(alu_op), .use_imm(use_imm), .instr_type(instr_type),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel), .trap(trap),
        .trap_cause(trap_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction from FETCH and summarise every cycle until FETCH returns.
    // rdy_at: MEM cycle (1-based) in which mem_ready is raised; 0 = never.
    task automatic run(input logic [31:0] ins, input int rdy_at, input logic taken);
        int c;
        instr = ins; instr_valid = 1'b1; branch_taken = taken;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; instr = 32'h0;
        s_pcw = 0; s_rw = 0; s_trap = 0; s_mem = 0;
        s_sel = 0; s_wb = 0; s_cause = 0; s_alu = 0; s_imm = 0; s_type = 0;
        c = 1;
        while (!fetch_req && c < 40) begin
            if (mem_read || mem_write) begin
                s_mem++;
                mem_ready = (s_mem == rdy_at);
            end
            #1;
            if (c == 1) s_type = 32'(instr_type);
            if (c == 2) begin s_alu = 32'(alu_op); s_imm = 32'(use_imm); end
            if (pc_write)  begin s_pcw++;  s_sel = 32'(pc_sel); end
            if (reg_write) begin s_rw++;   s_wb = 32'(wb_sel); end
            if (trap)      begin s_trap++; s_cause = 32'(trap_cause); end
            @(posedge clk); @(negedge clk);
            mem_ready = 1'b0;
            c++;
        end
        branch_taken = 1'b0;
        s_cyc = c;
        if (c >= 40) chk("hang", 32'(fetch_req), 32'd1);
    endtask

    task automatic expect_run(input string t, input int cpi, input int pcw, input int sel,
                              input int rw, input int wb, input int ntrap, input int nmem);
        chk({t, ".cpi"},  32'(s_cyc),  32'(cpi));
        chk({t, ".pcw"},  32'(s_pcw),  32'(pcw));
        chk({t, ".psel"}, s_sel,       32'(sel));
        chk({t, ".rw"},   32'(s_rw),   32'(rw));
        if (rw != 0) chk({t, ".wbsel"}, s_wb, 32'(wb));
        chk({t, ".trap"}, 32'(s_trap), 32'(ntrap));
        chk({t, ".mem"},  32'(s_mem),  32'(nmem));
    endtask

    initial begin
        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.mem_read", 32'(mem_read), 32'd0);
        chk("rst.trap_cause", 32'(trap_cause), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.fetch_req", 32'(fetch_req), 32'd1);
        chk("rst.pc_write", 32'(pc_write), 32'd0);
        chk("rst.reg_write", 32'(reg_write), 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'(ALU_ADD));

        run(32'h002081B3, 0, 1'b0);                 // add x3,x1,x2
        expect_run("add", 4, 1, 0, 1, 0, 0, 0);
        chk("add.alu", s_alu, 32'(ALU_ADD));
        chk("add.imm", s_imm, 32'd0);
        chk("add.type", s_type, 32'(R_TYPE));

        run(32'h402081B3, 0, 1'b0);                 // sub
        chk("sub.alu", s_alu, 32'(ALU_SUB));
        run(32'h4020D1B3, 0, 1'b0);                 // sra
        chk("sra.alu", s_alu, 32'(ALU_SRA));
        run(32'h4030D193, 0, 1'b0);                 // srai x3,x1,3
        chk("srai.alu", s_alu, 32'(ALU_SRA));
        chk("srai.imm", s_imm, 32'd1);
        expect_run("srai", 4, 1, 0, 1, 0, 0, 0);

        run(32'h022081B3, 0, 1'b0);                 // mul: illegal without M
        expect_run("mul", 3, 1, 3, 0, 0, 1, 0);
        chk("mul.cause", s_cause, 32'd0);

        run(32'h0000A283, 3, 1'b0);                 // lw, ready in 3rd MEM cycle
        expect_run("lw3", 7, 1, 0, 1, 1, 0, 3);

        run(32'h0000A283, 0, 1'b0);                 // lw, never ready -> timeout
        expect_run("lwto", 8, 1, 3, 0, 0, 1, 4);
        chk("lwto.cause", s_cause, 32'd3);

        run(32'h002081B3, 0, 1'b0);                 // cause holds across non-trap instr
        chk("hold.cause", 32'(trap_cause), 32'd3);

        run(32'h0000A283, 4, 1'b0);                 // ready in final cycle beats timeout
        expect_run("lw4", 8, 1, 0, 1, 1, 0, 4);

        run(32'h0020A023, 1, 1'b0);                 // sw
        expect_run("sw", 4, 1, 0, 0, 0, 0, 1);
        chk("sw.type", s_type, 32'(S_TYPE));

        run(32'h00208463, 0, 1'b1);                 // beq taken
        expect_run("beqT", 3, 1, 1, 0, 0, 0, 0);
        chk("beq.alu", s_alu, 32'(ALU_INVALID));
        run(32'h00208463, 0, 1'b0);                 // beq not taken
        expect_run("beqN", 3, 1, 0, 0, 0, 0, 0);

        run(32'h000280E7, 0, 1'b0);                 // jalr x1,0(x5)
        expect_run("jalr", 4, 1, 2, 1, 2, 0, 0);
        run(32'h010000EF, 0, 1'b0);                 // jal x1,16
        expect_run("jal", 4, 1, 1, 1, 2, 0, 0);

        run(32'h00000073, 0, 1'b0);                 // ecall
        expect_run("ecall", 4, 1, 3, 0, 0, 1, 0);
        chk("ecall.cause", s_cause, 32'd1);
        run(32'h00100073, 0, 1'b0);                 // ebreak
        chk("ebreak.cause", s_cause, 32'd2);

        run(32'h00000013, 0, 1'b0);                 // addi x0,x0,0
        expect_run("nop", 4, 1, 0, 0, 0, 0, 0);

        // reset while a load is waiting in MEM (trap_cause is 2 beforehand)
        instr = 32'h0000A283; instr_valid = 1'b1;
        @(posedge clk); @(negedge clk); instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("rmem.mem_read_before", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmem.mem_read", 32'(mem_read), 32'd0);
        chk("rmem.busy", 32'(busy), 32'd0);
        chk("rmem.cause", 32'(trap_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmem.fetch_req", 32'(fetch_req), 32'd1);
        run(32'h002081B3, 0, 1'b0);
        expect_run("post", 4, 1, 0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
